// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight branch predictions; resolves the head against execute
// results, trains the PHT and raises a fetch redirect on a mispredict.
module branch_resolve_queue #(
  parameter int PHT_ADDR_W = 10,
  parameter int DEPTH      = 4,
  parameter int PC_W       = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  input  logic [PHT_ADDR_W-1:0]        enq_pht_addr,
  input  logic                         enq_pred_dir,
  input  logic [PC_W-1:0]              enq_pred_target,
  input  logic                         res_valid,
  input  logic                         res_dir,
  input  logic [PC_W-1:0]              res_target,
  input  logic [PC_W-1:0]              res_fallthrough,
  output logic                         upd_valid,
  output logic [PHT_ADDR_W-1:0]        upd_pht_addr,
  output logic                         upd_dir,
  output logic                         mispredict,
  output logic [PC_W-1:0]              redirect_pc,
  output logic                         res_err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [PHT_ADDR_W-1:0] ent_pht [DEPTH];
  logic                  ent_dir [DEPTH];
  logic [PC_W-1:0]       ent_tgt [DEPTH];

  logic [PTR_W-1:0]      head_q, tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  active, do_res, do_enq, do_mis, res_empty;
  logic [PHT_ADDR_W-1:0] head_pht;
  logic                  head_dir;
  logic [PC_W-1:0]       head_tgt;

  assign count     = count_q;
  assign enq_ready = (count_q < FULL) && !stall;

  always_comb begin
    head_pht  = ent_pht[head_q];
    head_dir  = ent_dir[head_q];
    head_tgt  = ent_tgt[head_q];
    active    = !stall && !flush;
    do_res    = res_valid && active && (count_q != '0);
    res_empty = res_valid && active && (count_q == '0);
    do_mis    = do_res && ((res_dir != head_dir) ||
                           (res_dir && head_dir && (res_target != head_tgt)));
    // A mispredict squashes younger entries, including one arriving this cycle.
    do_enq    = enq_valid && enq_ready && !flush && !do_mis;
  end

  always_ff @(posedge clk) begin
    if (do_enq) begin
      ent_pht[tail_q] <= enq_pht_addr;
      ent_dir[tail_q] <= enq_pred_dir;
      ent_tgt[tail_q] <= enq_pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      upd_valid    <= 1'b0;
      upd_pht_addr <= '0;
      upd_dir      <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
      res_err      <= 1'b0;
    end else begin
      upd_valid  <= do_res;
      mispredict <= do_mis;
      res_err    <= res_empty;
      if (do_res) begin
        upd_pht_addr <= head_pht;
        upd_dir      <= res_dir;
      end
      if (do_mis) begin
        redirect_pc <= res_dir ? res_target : res_fallthrough;
      end

      if (flush || do_mis) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else if (!stall) begin
        if (do_enq) tail_q <= tail_q + PTR_W'(1);
        if (do_res) head_q <= head_q + PTR_W'(1);
        if (do_enq && !do_res)      count_q <= count_q + CNT_W'(1);
        else if (do_res && !do_enq) count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, stall/flush sequences,
// then random traffic against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        enq_valid = 1'b0, enq_pred_dir = 1'b0;
  logic [9:0]  enq_pht_addr = '0;
  logic [31:0] enq_pred_target = '0;
  logic        res_valid = 1'b0, res_dir = 1'b0;
  logic [31:0] res_target = '0, res_fallthrough = '0;
  logic        enq_ready, upd_valid, upd_dir, mispredict, res_err;
  logic [9:0]  upd_pht_addr;
  logic [31:0] redirect_pc;
  logic [2:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  branch_resolve_queue #(.PHT_ADDR_W(10), .DEPTH(DEPTH), .PC_W(32)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_pht_addr(enq_pht_addr),
    .enq_pred_dir(enq_pred_dir), .enq_pred_target(enq_pred_target),
    .res_valid(res_valid), .res_dir(res_dir), .res_target(res_target),
    .res_fallthrough(res_fallthrough), .upd_valid(upd_valid),
    .upd_pht_addr(upd_pht_addr), .upd_dir(upd_dir), .mispredict(mispredict),
    .redirect_pc(redirect_pc), .res_err(res_err), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, fl, ev; logic [9:0] ea; logic ed; logic [31:0] et;
    logic rv, rd; logic [31:0] rt, rf;
    logic x_rdy; int x_cnt; logic x_uv; logic [9:0] x_ua; logic x_ud;
    logic x_mp; logic [31:0] x_pc; logic x_err;
  } vec_t;

  typedef struct { logic [9:0] a; logic d; logic [31:0] t; } ent_t;

  vec_t vt[$];
  ent_t mq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called #1 after a posedge: drive, check enq_ready, step one clock, check outputs.
  task automatic run_vec(input vec_t v, input string tag);
    stall = v.st; flush = v.fl;
    enq_valid = v.ev; enq_pht_addr = v.ea; enq_pred_dir = v.ed; enq_pred_target = v.et;
    res_valid = v.rv; res_dir = v.rd; res_target = v.rt; res_fallthrough = v.rf;
    #1;
    chk({tag, ".enq_ready"}, 64'(enq_ready), 64'(v.x_rdy));
    @(posedge clk); #1;
    chk({tag, ".count"}, 64'(count), 64'(v.x_cnt));
    chk({tag, ".upd_valid"}, 64'(upd_valid), 64'(v.x_uv));
    chk({tag, ".mispredict"}, 64'(mispredict), 64'(v.x_mp));
    chk({tag, ".res_err"}, 64'(res_err), 64'(v.x_err));
    if (v.x_uv) begin
      chk({tag, ".upd_pht_addr"}, 64'(upd_pht_addr), 64'(v.x_ua));
      chk({tag, ".upd_dir"}, 64'(upd_dir), 64'(v.x_ud));
    end
    if (v.x_mp) chk({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(v.x_pc));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // st fl ev ea ed et | rv rd rt rf | rdy cnt uv ua ud mp pc err
    vt.push_back('{0,0,1,'h10,0,0,      0,0,0,0,          1,1,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h11,0,0,      0,0,0,0,          1,2,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h12,0,0,      0,0,0,0,          1,3,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h13,0,0,      0,0,0,0,          1,4,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h14,0,0,      0,0,0,0,          0,4,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h14,0,0,      1,0,0,'h104,      0,3,1,'h10,0,0,0,0});
    vt.push_back('{0,0,0,0,0,0,         1,0,0,'h108,      1,2,1,'h11,0,0,0,0});
    vt.push_back('{0,0,0,0,0,0,         1,0,0,'h10c,      1,1,1,'h12,0,0,0,0});
    vt.push_back('{0,0,0,0,0,0,         1,0,0,'h110,      1,0,1,'h13,0,0,0,0});
    vt.push_back('{0,0,1,'h20,1,'h400,  0,0,0,0,          1,1,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h21,0,0,      0,0,0,0,          1,2,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h22,0,0,      0,0,0,0,          1,3,0,0,0,0,0,0});
    vt.push_back('{0,0,0,0,0,0,         1,1,'h404,'h84,   1,0,1,'h20,1,1,'h404,0});
    vt.push_back('{0,0,1,'h30,1,'h800,  0,0,0,0,          1,1,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h31,0,0,      1,0,'h999,'h1008, 1,0,1,'h30,0,1,'h1008,0});
    vt.push_back('{0,0,1,'h40,1,'h500,  0,0,0,0,          1,1,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h41,0,0,      1,1,'h500,'h44,   1,1,1,'h40,1,0,0,0});
    vt.push_back('{0,0,1,'h42,0,0,      0,0,0,0,          1,2,0,0,0,0,0,0});
    vt.push_back('{0,0,1,'h43,0,0,      0,0,0,0,          1,3,0,0,0,0,0,0});
    vt.push_back('{0,1,1,'h44,0,0,      1,0,0,0,          1,0,0,0,0,0,0,0});
    vt.push_back('{0,0,0,0,0,0,         1,0,0,0,          1,0,0,0,0,0,0,1});
    vt.push_back('{0,0,0,0,0,0,         0,0,0,0,          1,0,0,0,0,0,0,0});

    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", 64'(count), 64'(0));
    chk("reset.enq_ready", 64'(enq_ready), 64'(1));
    chk("reset.upd_valid", 64'(upd_valid), 64'(0));
    chk("reset.mispredict", 64'(mispredict), 64'(0));
    chk("reset.res_err", 64'(res_err), 64'(0));
    chk("reset.upd_pht_addr", 64'(upd_pht_addr), 64'(0));
    chk("reset.upd_dir", 64'(upd_dir), 64'(0));
    chk("reset.redirect_pc", 64'(redirect_pc), 64'(0));
    resetn = 1'b1;

    foreach (vt[i]) run_vec(vt[i], $sformatf("vec%0d", i));

    // Stall sequence: two entries held while stall masks resolve and enqueue.
    run_vec('{0,0,1,'h50,0,0, 0,0,0,0, 1,1,0,0,0,0,0,0}, "stall.fill0");
    run_vec('{0,0,1,'h51,0,0, 0,0,0,0, 1,2,0,0,0,0,0,0}, "stall.fill1");
    for (int i = 0; i < 3; i++)
      run_vec('{1,0,1,'h52,0,0, 1,0,0,'h200, 0,2,0,0,0,0,0,0}, $sformatf("stall.hold%0d", i));
    run_vec('{0,0,0,0,0,0, 1,0,0,'h200, 1,1,1,'h50,0,0,0,0}, "stall.release");
    run_vec('{0,0,0,0,0,0, 0,0,0,0,     1,1,0,0,0,0,0,0}, "stall.after");
    run_vec('{0,1,0,0,0,0, 0,0,0,0,     1,0,0,0,0,0,0,0}, "stall.flush");

    // Random traffic against the reference queue (empty after the flush above).
    for (int c = 0; c < 400; c++) begin
      logic x_rdy, x_uv, x_ud, x_mp, x_err;
      logic [9:0] x_ua;
      logic [31:0] x_pc;
      ent_t e;
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      enq_valid = $urandom_range(1);
      enq_pht_addr = 10'($urandom);
      enq_pred_dir = $urandom_range(1);
      enq_pred_target = 32'($urandom_range(3)) << 4;
      res_valid = $urandom_range(1);
      res_dir = $urandom_range(1);
      res_target = 32'($urandom_range(3)) << 4;
      res_fallthrough = $urandom;
      #1;
      x_rdy = (mq.size() < DEPTH) && !stall;
      chk("rnd.enq_ready", 64'(enq_ready), 64'(x_rdy));
      x_uv = 0; x_ud = 0; x_mp = 0; x_err = 0; x_ua = '0; x_pc = '0;
      if (flush) mq.delete();
      else if (!stall) begin
        if (res_valid) begin
          if (mq.size() == 0) x_err = 1;
          else begin
            e = mq.pop_front();
            x_uv = 1; x_ua = e.a; x_ud = res_dir;
            x_mp = (res_dir != e.d) || (res_dir && res_target != e.t);
            x_pc = res_dir ? res_target : res_fallthrough;
            if (x_mp) mq.delete();
          end
        end
        if (enq_valid && x_rdy && !x_mp)
          mq.push_back('{enq_pht_addr, enq_pred_dir, enq_pred_target});
      end
      @(posedge clk); #1;
      chk("rnd.count", 64'(count), 64'(mq.size()));
      chk("rnd.upd_valid", 64'(upd_valid), 64'(x_uv));
      chk("rnd.mispredict", 64'(mispredict), 64'(x_mp));
      chk("rnd.res_err", 64'(res_err), 64'(x_err));
      if (x_uv) begin
        chk("rnd.upd_pht_addr", 64'(upd_pht_addr), 64'(x_ua));
        chk("rnd.upd_dir", 64'(upd_dir), 64'(x_ud));
      end
      if (x_mp) chk("rnd.redirect_pc", 64'(redirect_pc), 64'(x_pc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
